// File: rtl/crc8_rx_checker_pkg.sv
// ============================================================================
// Module   : crc8_rx_checker_pkg
// Brief    : Shared state encoding and CRC-8 (x^8+x^2+x+1) constants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package crc8_rx_checker_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [7:0] c_CRC8_POLY    = 8'h07;
  localparam logic [7:0] c_CRC8_RESIDUE = 8'h00;

endpackage

`default_nettype wire

// File: rtl/crc8_rx_checker_crc8.sv
// ============================================================================
// Module   : crc8_rx_checker_crc8
// Brief    : Combinational one-byte CRC-8 update, MSB first, poly 0x07.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc8_rx_checker_crc8
  import crc8_rx_checker_pkg::*;
(
  input  logic [7:0] i_crc,
  input  logic [7:0] i_data,
  output logic [7:0] o_crc
);

  logic [7:0] w_c;

  always_comb begin
    w_c = i_crc ^ i_data;
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[7] ? ((w_c << 1) ^ c_CRC8_POLY) : (w_c << 1);
    end
  end

  assign o_crc = w_c;

endmodule

`default_nettype wire

// File: rtl/crc8_rx_checker.sv
// ============================================================================
// Module   : crc8_rx_checker
// Brief    : CRC-8 frame checker: strips the trailing CRC byte, forwards the
//            payload with last/crc_ok flags, counts frames and errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc8_rx_checker
  import crc8_rx_checker_pkg::*;
#(
  parameter logic [7:0] CRC_INIT = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_s_data,
  input  logic             i_s_valid,
  input  logic             i_s_last,
  output logic             o_s_ready,
  output logic [7:0]       o_m_data,
  output logic             o_m_valid,
  output logic             o_m_last,
  output logic             o_m_crc_ok,
  input  logic             i_m_ready,
  output logic             o_runt,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  state_t     r_state;
  logic [7:0] r_hold;
  logic [7:0] r_crc;
  logic       r_active;

  logic [7:0] w_crc_seed;
  logic [7:0] w_crc_next;
  logic       w_idle;
  logic       w_accept;
  logic       w_emit;
  logic       w_crc_ok;
  logic       w_frame_end;
  logic       w_err;

  crc8_rx_checker_crc8 u_crc8 (
    .i_crc  (w_crc_seed),
    .i_data (i_s_data),
    .o_crc  (w_crc_next)
  );

  // r_active keeps o_s_ready low while reset is held and for the release cycle.
  assign w_idle      = (r_state == S_IDLE);
  assign w_crc_seed  = w_idle ? CRC_INIT : r_crc;
  assign o_s_ready   = r_active & (w_idle | ~o_m_valid | i_m_ready);
  assign w_accept    = i_s_valid & o_s_ready;
  assign w_emit      = w_accept & ~w_idle;
  assign w_crc_ok    = (w_crc_next == c_CRC8_RESIDUE);
  assign w_frame_end = w_accept & i_s_last;
  assign w_err       = w_frame_end & (w_idle | ~w_crc_ok);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_hold      <= 8'h00;
      r_crc       <= CRC_INIT;
      r_active    <= 1'b0;
      o_m_data    <= 8'h00;
      o_m_valid   <= 1'b0;
      o_m_last    <= 1'b0;
      o_m_crc_ok  <= 1'b0;
      o_runt      <= 1'b0;
      o_frame_cnt <= '0;
      o_err_cnt   <= '0;
    end else begin
      r_active <= 1'b1;
      o_runt   <= w_frame_end & w_idle;

      if (w_emit) begin
        o_m_data   <= r_hold;
        o_m_valid  <= 1'b1;
        o_m_last   <= i_s_last;
        o_m_crc_ok <= i_s_last & w_crc_ok;
      end else if (i_m_ready) begin
        o_m_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept && !i_s_last) begin
            r_state <= S_HOLD;
            r_hold  <= i_s_data;
            r_crc   <= w_crc_next;
          end
        end
        S_HOLD: begin
          if (w_accept) begin
            if (i_s_last) begin
              r_state <= S_IDLE;
              r_crc   <= CRC_INIT;
            end else begin
              r_hold <= i_s_data;
              r_crc  <= w_crc_next;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_frame_end && (o_frame_cnt != '1)) o_frame_cnt <= o_frame_cnt + CNT_W'(1);
      if (w_err && (o_err_cnt != '1))         o_err_cnt   <= o_err_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_crc8_rx_checker.sv
// ============================================================================
// Module   : tb_crc8_rx_checker
// Brief    : Directed-vector scoreboard bench for crc8_rx_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc8_rx_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst2_n = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b1;
  logic        tog = 1'b0;

  logic        o_s_ready, o_m_valid, o_m_last, o_m_crc_ok, o_runt;
  logic [7:0]  o_m_data;
  logic [15:0] o_frame_cnt, o_err_cnt;

  logic        s_ready2, m_valid2, m_last2, m_crc_ok2, runt2;
  logic [7:0]  m_data2;
  logic [1:0]  frame_cnt2, err_cnt2;

  int n_checks = 0;
  int n_err = 0;
  int runt_seen = 0;
  logic [9:0] sb[$];

  logic [7:0] good[10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                           8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};

  always #5 clk = ~clk;

  crc8_rx_checker dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_s_data(s_data), .i_s_valid(s_valid), .i_s_last(s_last), .o_s_ready(o_s_ready),
    .o_m_data(o_m_data), .o_m_valid(o_m_valid), .o_m_last(o_m_last),
    .o_m_crc_ok(o_m_crc_ok), .i_m_ready(m_ready), .o_runt(o_runt),
    .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
  );

  crc8_rx_checker #(.CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst2_n),
    .i_s_data(s_data), .i_s_valid(s_valid), .i_s_last(s_last), .o_s_ready(s_ready2),
    .o_m_data(m_data2), .o_m_valid(m_valid2), .o_m_last(m_last2),
    .o_m_crc_ok(m_crc_ok2), .i_m_ready(1'b1), .o_runt(runt2),
    .o_frame_cnt(frame_cnt2), .o_err_cnt(err_cnt2)
  );

  // Monitor: every downstream transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && o_m_valid && m_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out got data=%h last=%b ok=%b want none",
                 o_m_data, o_m_last, o_m_crc_ok);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        if ({o_m_data, o_m_last, o_m_crc_ok} !== e) begin
          n_err++;
          $display("FAIL out_byte got data=%h last=%b ok=%b want data=%h last=%b ok=%b",
                   o_m_data, o_m_last, o_m_crc_ok, e[9:2], e[1], e[0]);
        end
      end
    end
    if (o_runt) runt_seen++;
  end

  always @(posedge clk) begin
    #1;
    if (tog) m_ready = ~m_ready;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    s_data = d; s_valid = 1'b1; s_last = l;
    @(negedge clk);
    while (!o_s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++; n_err++;
      $display("FAIL send_timeout got ready=0 want ready=1 byte=%h", d);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic l, input logic ok);
    sb.push_back({d, l, ok});
  endtask

  task automatic send_good(input logic [7:0] crc, input logic ok);
    for (int i = 0; i < 9; i++) push(good[i], i == 8, (i == 8) && ok);
    for (int i = 0; i < 9; i++) send(good[i], 1'b0);
    send(crc, 1'b1);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check(name, sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string name, input int f, input int e);
    check({name, "_frames"}, int'(o_frame_cnt), f);
    check({name, "_errs"}, int'(o_err_cnt), e);
  endtask

  initial begin
    int r0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", o_s_ready, 0);
    check("rst_valid", o_m_valid, 0);
    check("rst_cnt", int'(o_frame_cnt) + int'(o_err_cnt) + int'(o_runt), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send_good(8'hF4, 1'b1);
    drain("good_drain");
    check_cnt("good", 1, 0);

    send_good(8'hF5, 1'b0);
    drain("bad_drain");
    check_cnt("bad", 2, 1);

    r0 = runt_seen;
    send(8'h5A, 1'b1);
    drain("runt_drain");
    check("runt_pulse", runt_seen - r0, 1);
    check_cnt("runt", 3, 2);

    // Downstream ready toggles every clock: nothing may be lost or repeated.
    tog = 1'b1;
    push(8'h01, 1'b1, 1'b1);
    send(8'h01, 1'b0);
    send(8'h07, 1'b1);
    send_good(8'hF4, 1'b1);
    drain("toggle_drain");
    tog = 1'b0;
    m_ready = 1'b1;
    check_cnt("toggle", 5, 2);

    // Abort mid-frame: 31,32 already forwarded; held 33 must vanish.
    push(8'h31, 1'b0, 1'b0);
    push(8'h32, 1'b0, 1'b0);
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    send(8'h33, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("abort_valid", o_m_valid, 0);
    check("abort_ready", o_s_ready, 0);
    check("abort_q", sb.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_cnt("abort_clear", 0, 0);
    send_good(8'hF4, 1'b1);
    drain("abort_drain");
    check_cnt("after_abort", 1, 0);

    // Narrow-counter instance is brought out of reset only for this section.
    rst2_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int f = 0; f < 5; f++) begin
      push(8'h01, 1'b1, 1'b0);
      send(8'h01, 1'b0);
      send(8'h00, 1'b1);
      drain("sat_drain");
      if (f == 0) begin
        check("sat_first_frames", int'(frame_cnt2), 1);
        check("sat_first_errs", int'(err_cnt2), 1);
      end
    end
    check("sat_frames", int'(frame_cnt2), 3);
    check("sat_errs", int'(err_cnt2), 3);
    check_cnt("wide", 6, 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
